vx_pending_picker: RTL and testbench



---
 rtl/vx_pending_picker_if.sv | 41 ++++
 rtl/vx_pending_picker.sv | 91 +++++++++
 tb/tb_vx_pending_picker.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/vx_pending_picker_if.sv
// Bundle between the pending picker, its priority encoder and the downstream
// consumer of the selected index.
`timescale 1ns/1ps

interface vx_pending_picker_if #(
    parameter int NUM_REQS  = 4,
    parameter int LNUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
);
    logic [NUM_REQS-1:0]  set_mask;
    logic [NUM_REQS-1:0]  pending_out;
    logic [LNUM_REQS-1:0] enc_index;
    logic                 enc_valid;
    logic                 out_valid;
    logic [LNUM_REQS-1:0] out_index;
    logic                 out_ready;
    logic                 idle;

    // Picker side of the bundle.
    modport master (
        input  set_mask,
        input  enc_index,
        input  enc_valid,
        input  out_ready,
        output pending_out,
        output out_valid,
        output out_index,
        output idle
    );

    // Requester / encoder / consumer side of the bundle.
    modport slave (
        output set_mask,
        output enc_index,
        output enc_valid,
        output out_ready,
        input  pending_out,
        input  out_valid,
        input  out_index,
        input  idle
    );
endinterface

// File: rtl/vx_pending_picker.sv
// Sticky pending-request tracker feeding a lowest-first priority encoder and
// registering its pick into a valid/ready slot. VX_PICKER_RR_EN adds round-robin masking.
`timescale 1ns/1ps

module vx_pending_picker #(
    parameter int NUM_REQS  = 4,
    parameter int LNUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic clk,
    input  logic reset,
    vx_pending_picker_if.master bus
);

    // Out-of-range indices decode to an empty mask so nothing gets cleared.
    function automatic logic [NUM_REQS-1:0] idx_onehot(input logic [LNUM_REQS-1:0] idx);
        logic [NUM_REQS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (int'(idx) == i) m[i] = 1'b1;
        end
        return m;
    endfunction

    logic [NUM_REQS-1:0]  pending_p0;
    logic                 vld_p1;
    logic [LNUM_REQS-1:0] idx_p1;

    logic                 load;
    logic [NUM_REQS-1:0]  clr;
    logic [NUM_REQS-1:0]  pending_nxt;

    // Refill is allowed while the slot drains, giving one index per cycle.
    assign load        = bus.enc_valid & (~vld_p1 | bus.out_ready);
    assign clr         = load ? idx_onehot(bus.enc_index) : '0;
    assign pending_nxt = (pending_p0 & ~clr) | bus.set_mask;

    // ---- stage p0: pending accumulation ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_p0 <= '0;
        end else begin
            pending_p0 <= pending_nxt;
        end
    end

    // ---- stage p1: output slot ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            idx_p1 <= '0;
        end else if (load) begin
            vld_p1 <= 1'b1;
            idx_p1 <= bus.enc_index;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

`ifdef VX_PICKER_RR_EN
    function automatic logic [NUM_REQS-1:0] above_mask(input logic [LNUM_REQS-1:0] last);
        logic [NUM_REQS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (i > int'(last)) m[i] = 1'b1;
        end
        return m;
    endfunction

    logic [LNUM_REQS-1:0] last_idx;
    logic [NUM_REQS-1:0]  hi_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_idx <= '0;
        end else if (load) begin
            last_idx <= bus.enc_index;
        end
    end

    // Lines above the last winner go first; wrap to the full mask when none remain.
    assign hi_pending      = pending_p0 & above_mask(last_idx);
    assign bus.pending_out = (hi_pending != '0) ? hi_pending : pending_p0;
`else
    assign bus.pending_out = pending_p0;
`endif

    assign bus.out_valid = vld_p1;
    assign bus.out_index = idx_p1;
    assign bus.idle      = (pending_p0 == '0) & ~vld_p1;

endmodule

// File: tb/tb_vx_pending_picker.sv
// Bench for vx_pending_picker: directed scenarios plus random traffic checked
// against a behavioural scheduler model; the bench also plays the encoder.
`timescale 1ns/1ps

module tb_vx_pending_picker;

    localparam int N  = 4;
    localparam int LN = 2;

    logic clk = 1'b0;
    logic reset;

    vx_pending_picker_if #(.NUM_REQS(N), .LNUM_REQS(LN)) bus ();

    vx_pending_picker #(.NUM_REQS(N), .LNUM_REQS(LN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Lowest-set-bit encoder attached to the picker's mask output.
    always_comb begin
        bus.enc_valid = 1'b0;
        bus.enc_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.pending_out[i]) begin
                bus.enc_valid = 1'b1;
                bus.enc_index = LN'(i);
            end
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference scheduler state
    logic [N-1:0] m_pend;
    bit           m_vld;
    int           m_idx;
    int           m_last;

    function automatic logic [N-1:0] m_view();
        logic [N-1:0] hi;
        hi = '0;
`ifdef VX_PICKER_RR_EN
        for (int i = 0; i < N; i++) if (m_pend[i] && i > m_last) hi[i] = 1'b1;
        if (hi != '0) return hi;
`endif
        return m_pend;
    endfunction

    task automatic m_reset();
        m_pend = '0;
        m_vld  = 0;
        m_idx  = 0;
        m_last = 0;
    endtask

    task automatic m_advance(input logic [N-1:0] set, input bit rdy);
        logic [N-1:0] v;
        int pick;
        v = m_view();
        pick = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i]) pick = i;
        if (pick >= 0 && (!m_vld || rdy)) begin
            m_vld  = 1;
            m_idx  = pick;
            m_last = pick;
            m_pend[pick] = 1'b0;
        end else if (rdy) begin
            m_vld = 0;
        end
        m_pend = m_pend | set;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pending_out", 32'(bus.pending_out), 32'(m_view()));
        chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
        if (m_vld) chk("out_index", 32'(bus.out_index), 32'(m_idx));
        chk("idle", 32'(bus.idle), 32'((m_pend == '0) && !m_vld));
    endtask

    // One clock: drive inputs, let the edge pass, update model, compare.
    task automatic step(input logic [N-1:0] set, input bit rdy);
        bus.set_mask  = set;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
        m_advance(set, rdy);
        check_all();
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_idle", 32'(bus.idle), 32'd1);
        chk("rst_pending_out", 32'(bus.pending_out), 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

`ifdef VX_PICKER_RR_EN
    int served[$];
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.set_mask  = '0;
        bus.out_ready = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        chk("reset_pending_out", 32'(bus.pending_out), 32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_idle", 32'(bus.idle), 32'd1);
        reset = 1'b0;

        // Single pulse on line 2
        step(4'b0100, 1'b1);
        chk("single_pending", 32'(bus.pending_out), 32'h4);
        step(4'b0000, 1'b1);
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_index", 32'(bus.out_index), 32'd2);
        chk("single_drained", 32'(bus.pending_out), 32'd0);
        step(4'b0000, 1'b1);
        chk("single_idle", 32'(bus.idle), 32'd1);

`ifndef VX_PICKER_RR_EN
        // Fixed priority order 0,1,3
        step(4'b1011, 1'b1);
        step(4'b0000, 1'b1);
        chk("fixed_idx0", 32'(bus.out_index), 32'd0);
        step(4'b0000, 1'b1);
        chk("fixed_idx1", 32'(bus.out_index), 32'd1);
        step(4'b0000, 1'b1);
        chk("fixed_idx3", 32'(bus.out_index), 32'd3);
        step(4'b0000, 1'b1);
        chk("fixed_done", 32'(bus.out_valid), 32'd0);
`endif

        // Backpressure holds the slot while pending accumulates
        async_reset();
        step(4'b0011, 1'b0);
        step(4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(4'b0000, 1'b0);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_index", 32'(bus.out_index), 32'd0);
            chk("bp_pending", 32'(bus.pending_out), 32'h2);
        end
        step(4'b0000, 1'b1);
        chk("bp_release_index", 32'(bus.out_index), 32'd1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Set and clear colliding on the same line: set wins
        async_reset();
        step(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        chk("coll_pending", 32'(bus.pending_out), 32'h1);
        chk("coll_index", 32'(bus.out_index), 32'd0);
        step(4'b0000, 1'b1);
        chk("coll_reissue_valid", 32'(bus.out_valid), 32'd1);
        chk("coll_reissue_index", 32'(bus.out_index), 32'd0);
        chk("coll_cleared", 32'(bus.pending_out), 32'd0);

        // Reset while the slot holds an index drops it at once
        step(4'b1000, 1'b0);
        step(4'b0110, 1'b0);
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        async_reset();

`ifdef VX_PICKER_RR_EN
        // Saturating requests: every window of four picks is distinct
        for (int c = 0; c < 12; c++) begin
            step(4'b1111, 1'b1);
            if (bus.out_valid) served.push_back(int'(bus.out_index));
        end
        for (int s = 0; s + 3 < served.size(); s++) begin
            int seen;
            seen = 0;
            for (int k = 0; k < 4; k++) seen |= (1 << served[s + k]);
            chk("rr_window", 32'(seen), 32'hF);
        end
        bus.set_mask = '0;
        for (int c = 0; c < 6; c++) step(4'b0000, 1'b1);
`endif

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] s;
            bit r;
            s = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            r = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 60) == 0) async_reset();
            else step(s, r);
        end

        for (int c = 0; c < 8; c++) step(4'b0000, 1'b1);
        chk("final_idle", 32'(bus.idle), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
